// File: rtl/cell_redraw_seq_if.sv
// Painter handshake bundle: the sequencer starts one box at a time, and the painter
// answers with busy and a one-cycle done.
interface cell_redraw_seq_if #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int CW = 9
);
  logic          kick;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [CW-1:0] paint_color;
  logic          busy;
  logic          done;

  modport master (output kick, x0, y0, paint_color, input busy, done);
  modport slave  (input kick, x0, y0, paint_color, output busy, done);
endinterface

// File: rtl/cell_redraw_seq.sv
// Playfield display sequencer: full-field clear plus erase-old/draw-new redraws of the
// active piece, issued one box at a time to the painter.
module cell_redraw_seq #(
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int CXW      = 4,
  parameter int CYW      = 5,
  parameter int CELL_W   = 64,
  parameter int CELL_H   = 24,
  parameter int NCELLS   = 4,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int CW       = 9,
  parameter int BG_COLOR = 0
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   clear_req,
  input  logic                   redraw_req,
  input  logic [NCELLS*CXW-1:0]  cur_x,
  input  logic [NCELLS*CYW-1:0]  cur_y,
  input  logic [CW-1:0]          cur_color,
  cell_redraw_seq_if.master      pnt,
  output logic                   seq_busy,
  output logic                   frame_done
);
  typedef enum logic [2:0] {
    IDLE, CLR_ISSUE, CLR_WAIT, ERS_ISSUE, ERS_WAIT, DRW_ISSUE, DRW_WAIT
  } state_t;

  localparam int KW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  state_t                state, state_n;
  logic [CXW-1:0]        cx, cx_n;
  logic [CYW-1:0]        cy, cy_n;
  logic [KW-1:0]         k, k_n;
  logic [NCELLS*CXW-1:0] new_x, new_x_n, prev_x, prev_x_n;
  logic [NCELLS*CYW-1:0] new_y, new_y_n, prev_y, prev_y_n;
  logic [CW-1:0]         new_color, new_color_n;
  logic                  prev_valid, prev_valid_n, clr_pend, clr_pend_n, draw_pend, draw_pend_n;
  logic                  kick, kick_n, frame_done_n;
  logic [XW-1:0]         x0, x0_n;
  logic [YW-1:0]         y0, y0_n;
  logic [CW-1:0]         color, color_n;
  logic [CXW-1:0]        ers_cx, drw_cx;
  logic [CYW-1:0]        ers_cy, drw_cy;
  logic                  ers_skip, drw_skip, last_cell, boundary, fin, redraw_fin;

  always_comb begin
    ers_cx    = prev_x[k*CXW +: CXW];
    ers_cy    = prev_y[k*CYW +: CYW];
    drw_cx    = new_x[k*CXW +: CXW];
    drw_cy    = new_y[k*CYW +: CYW];
    last_cell = (int'(k) == NCELLS - 1);
    drw_skip  = (int'(drw_cx) >= COLS) || (int'(drw_cy) >= ROWS);
    ers_skip  = !prev_valid || (int'(ers_cx) >= COLS) || (int'(ers_cy) >= ROWS);
    // An old cell still covered by the new piece would be repainted anyway, so skip its erase.
    for (int unsigned j = 0; j < NCELLS; j++)
      if (ers_cx == new_x[j*CXW +: CXW] && ers_cy == new_y[j*CYW +: CYW]) ers_skip = 1'b1;
  end

  always_comb begin
    state_n      = state;
    cx_n         = cx;
    cy_n         = cy;
    k_n          = k;
    new_x_n      = new_x;
    new_y_n      = new_y;
    new_color_n  = new_color;
    prev_x_n     = prev_x;
    prev_y_n     = prev_y;
    prev_valid_n = prev_valid;
    clr_pend_n   = clr_pend | clear_req;
    draw_pend_n  = draw_pend | redraw_req;
    kick_n       = 1'b0;
    x0_n         = x0;
    y0_n         = y0;
    color_n      = color;
    frame_done_n = 1'b0;
    boundary     = 1'b0;
    fin          = 1'b0;
    redraw_fin   = 1'b0;

    case (state)
      IDLE: fin = 1'b1;
      CLR_ISSUE: if (!pnt.busy) begin
        kick_n  = 1'b1;
        x0_n    = XW'(int'(cx) * CELL_W);
        y0_n    = YW'(int'(cy) * CELL_H);
        color_n = CW'(BG_COLOR);
        state_n = CLR_WAIT;
      end
      CLR_WAIT: if (pnt.done) begin
        boundary = 1'b1;
        state_n  = CLR_ISSUE;
        if (int'(cx) == COLS - 1) begin
          cx_n = '0;
          if (int'(cy) == ROWS - 1) begin
            cy_n         = '0;
            prev_valid_n = 1'b0;
            frame_done_n = 1'b1;
            fin          = 1'b1;
          end else begin
            cy_n = cy + CYW'(1);
          end
        end else begin
          cx_n = cx + CXW'(1);
        end
      end
      ERS_ISSUE: if (ers_skip) begin
        k_n = last_cell ? '0 : k + KW'(1);
        if (last_cell) state_n = DRW_ISSUE;
      end else if (!pnt.busy) begin
        kick_n  = 1'b1;
        x0_n    = XW'(int'(ers_cx) * CELL_W);
        y0_n    = YW'(int'(ers_cy) * CELL_H);
        color_n = CW'(BG_COLOR);
        state_n = ERS_WAIT;
      end
      ERS_WAIT: if (pnt.done) begin
        boundary = 1'b1;
        k_n      = last_cell ? '0 : k + KW'(1);
        state_n  = last_cell ? DRW_ISSUE : ERS_ISSUE;
      end
      DRW_ISSUE: if (drw_skip) begin
        if (last_cell) redraw_fin = 1'b1;
        else k_n = k + KW'(1);
      end else if (!pnt.busy) begin
        kick_n  = 1'b1;
        x0_n    = XW'(int'(drw_cx) * CELL_W);
        y0_n    = YW'(int'(drw_cy) * CELL_H);
        color_n = new_color;
        state_n = DRW_WAIT;
      end
      DRW_WAIT: if (pnt.done) begin
        boundary = 1'b1;
        if (last_cell) redraw_fin = 1'b1;
        else begin
          k_n     = k + KW'(1);
          state_n = DRW_ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (redraw_fin) begin
      prev_x_n     = new_x;
      prev_y_n     = new_y;
      prev_valid_n = 1'b1;
      frame_done_n = 1'b1;
      fin          = 1'b1;
    end
    if (fin) state_n = IDLE;

    // Pending clear preempts anything at a box boundary; a pending redraw waits for sequence end.
    if (boundary || fin) begin
      if (clr_pend) begin
        state_n    = CLR_ISSUE;
        cx_n       = '0;
        cy_n       = '0;
        clr_pend_n = clear_req;
      end else if (fin && (draw_pend || redraw_req)) begin
        state_n     = ERS_ISSUE;
        k_n         = '0;
        new_x_n     = cur_x;
        new_y_n     = cur_y;
        new_color_n = cur_color;
        draw_pend_n = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= CLR_ISSUE;
      cx         <= '0;
      cy         <= '0;
      k          <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_color  <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
      clr_pend   <= 1'b0;
      draw_pend  <= 1'b1;
      kick       <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      color      <= '0;
      frame_done <= 1'b0;
      seq_busy   <= 1'b0;
    end else begin
      state      <= state_n;
      cx         <= cx_n;
      cy         <= cy_n;
      k          <= k_n;
      new_x      <= new_x_n;
      new_y      <= new_y_n;
      new_color  <= new_color_n;
      prev_x     <= prev_x_n;
      prev_y     <= prev_y_n;
      prev_valid <= prev_valid_n;
      clr_pend   <= clr_pend_n;
      draw_pend  <= draw_pend_n;
      kick       <= kick_n;
      x0         <= x0_n;
      y0         <= y0_n;
      color      <= color_n;
      frame_done <= frame_done_n;
      seq_busy   <= (state_n != IDLE);
    end
  end

  assign pnt.kick        = kick;
  assign pnt.x0          = x0;
  assign pnt.y0          = y0;
  assign pnt.paint_color = color;
endmodule

// File: tb/tb_cell_redraw_seq.sv
// Directed bench for cell_redraw_seq with a 5-cycle-busy painter model and a kick log.
module tb_cell_redraw_seq;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clear_req = 1'b0;
  logic        redraw_req = 1'b0;
  logic [15:0] cur_x = '0;
  logic [19:0] cur_y = '0;
  logic [8:0]  cur_color = '0;
  logic        seq_busy, frame_done;

  int checks = 0;
  int errors = 0;
  int proto_err = 0;
  int fd_cnt = 0;
  int pcnt;
  logic [27:0] kq[$];

  cell_redraw_seq_if #(.XW(10), .YW(9), .CW(9)) pnt ();

  cell_redraw_seq dut (
    .CLOCK_50(clk), .resetn(resetn), .clear_req(clear_req), .redraw_req(redraw_req),
    .cur_x(cur_x), .cur_y(cur_y), .cur_color(cur_color), .pnt(pnt),
    .seq_busy(seq_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Painter: busy for 5 cycles after a kick, then a one-cycle done.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pnt.busy <= 1'b0;
      pnt.done <= 1'b0;
      pcnt     <= 0;
    end else begin
      pnt.done <= 1'b0;
      if (pnt.kick) begin
        if (pnt.busy) proto_err <= proto_err + 1;
        pnt.busy <= 1'b1;
        pcnt     <= 4;
      end else if (pnt.busy) begin
        if (pcnt == 0) begin
          pnt.busy <= 1'b0;
          pnt.done <= 1'b1;
        end else pcnt <= pcnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (pnt.kick) kq.push_back({pnt.x0, pnt.y0, pnt.paint_color});
    if (frame_done) fd_cnt++;
  end

  function automatic logic [27:0] ent(input int x, input int y, input int c);
    return {10'(x), 9'(y), 9'(c)};
  endfunction

  task automatic set_cell(input int k, input int x, input int y);
    cur_x[k*4 +: 4] = 4'(x);
    cur_y[k*5 +: 5] = 5'(y);
  endtask

  task automatic set_row(input int xs, input int y, input int c);
    for (int k = 0; k < 4; k++) set_cell(k, xs + k, y);
    cur_color = 9'(c);
  endtask

  task automatic pulse_redraw();
    @(negedge clk); redraw_req = 1'b1;
    @(negedge clk); redraw_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (fd_cnt >= target && !seq_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok; int b; logic [27:0] exp_q[$]; logic [27:0] got;
    set_cell(0, 0, 0); set_cell(1, 1, 0); set_cell(2, 2, 0); set_cell(3, 1, 1);
    cur_color = 9'h1C0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pnt.kick !== 1'b0 || seq_busy !== 1'b0 || frame_done !== 1'b0 || pnt.x0 !== 10'd0 || pnt.y0 !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: kick=%b seq_busy=%b frame_done=%b x0=%0d y0=%0d, required all 0",
               pnt.kick, seq_busy, frame_done, pnt.x0, pnt.y0);
    end
    b = kq.size();
    resetn = 1'b1;
    wait_done(2, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_timeout: sequence did not complete, fd=%0d required 2", fd_cnt); end
    checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL reset_frames: got %0d required 2", fd_cnt); end
    checks++; if (kq.size() - b !== 204) begin errors++; $display("FAIL reset_kicks: got %0d required 204", kq.size() - b); end
    for (int i = 0; i < 200; i++) exp_q.push_back(ent((i % 10) * 64, (i / 10) * 24, 0));
    exp_q.push_back(ent(0, 0, 'h1C0));  exp_q.push_back(ent(64, 0, 'h1C0));
    exp_q.push_back(ent(128, 0, 'h1C0)); exp_q.push_back(ent(64, 24, 'h1C0));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (b + i < kq.size()) ? kq[b + i] : 'x;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL reset_box[%0d]: got %h required %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_shift();
    bit ok; int b; int f; logic [27:0] exp_q[$]; logic [27:0] got;
    set_row(3, 0, 'h038);
    b = kq.size(); f = fd_cnt;
    pulse_redraw();
    wait_done(f + 1, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL shift1_timeout: fd=%0d required %0d", fd_cnt, f + 1); end
    exp_q = '{ent(0, 0, 0), ent(64, 0, 0), ent(128, 0, 0), ent(64, 24, 0),
              ent(192, 0, 'h038), ent(256, 0, 'h038), ent(320, 0, 'h038), ent(384, 0, 'h038)};
    checks++; if (kq.size() - b !== 8) begin errors++; $display("FAIL shift1_kicks: got %0d required 8", kq.size() - b); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (b + i < kq.size()) ? kq[b + i] : 'x;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL shift1_box[%0d]: got %h required %h", i, got, exp_q[i]); end
    end
    set_row(4, 0, 'h038);
    b = kq.size(); f = fd_cnt;
    @(negedge clk); redraw_req = 1'b1;
    @(negedge clk); redraw_req = 1'b0;
    checks++; if (pnt.kick !== 1'b0) begin errors++; $display("FAIL shift_latency_t1: kick=%b required 0", pnt.kick); end
    @(negedge clk);
    checks++; if (pnt.kick !== 1'b1) begin errors++; $display("FAIL shift_latency_t2: kick=%b required 1", pnt.kick); end
    wait_done(f + 1, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL shift2_timeout: fd=%0d required %0d", fd_cnt, f + 1); end
    exp_q = '{ent(192, 0, 0), ent(256, 0, 'h038), ent(320, 0, 'h038), ent(384, 0, 'h038), ent(448, 0, 'h038)};
    checks++; if (kq.size() - b !== 5) begin errors++; $display("FAIL shift2_kicks: got %0d required 5", kq.size() - b); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (b + i < kq.size()) ? kq[b + i] : 'x;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL shift2_box[%0d]: got %h required %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_coalesce();
    bit ok; int b; int f; int sz; logic [27:0] exp_q[$]; logic [27:0] got;
    set_row(4, 1, 'h111);
    b = kq.size(); f = fd_cnt;
    pulse_redraw();
    set_row(4, 2, 'h1AA);
    repeat (10) @(negedge clk); pulse_redraw();
    repeat (7) @(negedge clk);  pulse_redraw();
    repeat (13) @(negedge clk); pulse_redraw();
    wait_done(f + 2, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL coalesce_timeout: fd=%0d required %0d", fd_cnt, f + 2); end
    sz = kq.size();
    repeat (40) @(negedge clk);
    checks++; if (kq.size() !== sz || seq_busy !== 1'b0) begin
      errors++; $display("FAIL coalesce_extra: kicks %0d->%0d seq_busy=%b, required no change and 0", sz, kq.size(), seq_busy);
    end
    checks++; if (fd_cnt - f !== 2) begin errors++; $display("FAIL coalesce_frames: got %0d required 2", fd_cnt - f); end
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(256 + 64 * i, 0, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(256 + 64 * i, 24, 'h111));
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(256 + 64 * i, 24, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(256 + 64 * i, 48, 'h1AA));
    checks++; if (kq.size() - b !== 16) begin errors++; $display("FAIL coalesce_kicks: got %0d required 16", kq.size() - b); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (b + i < kq.size()) ? kq[b + i] : 'x;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL coalesce_box[%0d]: got %h required %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_clear_abort();
    bit ok; int b; int f; logic [27:0] exp_q[$]; logic [27:0] got;
    set_row(0, 5, 'h0C3);
    b = kq.size(); f = fd_cnt;
    pulse_redraw();
    for (int n = 0; n < 50 && kq.size() <= b; n++) @(negedge clk);
    @(negedge clk); clear_req = 1'b1; redraw_req = 1'b1;
    @(negedge clk); clear_req = 1'b0; redraw_req = 1'b0;
    wait_done(f + 2, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_timeout: fd=%0d required %0d", fd_cnt, f + 2); end
    checks++; if (fd_cnt - f !== 2) begin errors++; $display("FAIL abort_frames: got %0d required 2", fd_cnt - f); end
    exp_q.push_back(ent(256, 48, 0));
    for (int i = 0; i < 200; i++) exp_q.push_back(ent((i % 10) * 64, (i / 10) * 24, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(64 * i, 120, 'h0C3));
    checks++; if (kq.size() - b !== 205) begin errors++; $display("FAIL abort_kicks: got %0d required 205", kq.size() - b); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (b + i < kq.size()) ? kq[b + i] : 'x;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL abort_box[%0d]: got %h required %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_out_of_range();
    bit ok; int b; int f; logic [27:0] exp_q[$]; logic [27:0] got;
    set_cell(0, 12, 6); set_cell(1, 1, 6); set_cell(2, 2, 6); set_cell(3, 3, 6);
    cur_color = 9'h0F0;
    b = kq.size(); f = fd_cnt;
    pulse_redraw();
    wait_done(f + 1, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL oor1_timeout: fd=%0d required %0d", fd_cnt, f + 1); end
    set_row(0, 7, 'h00F);
    pulse_redraw();
    wait_done(f + 2, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL oor2_timeout: fd=%0d required %0d", fd_cnt, f + 2); end
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(64 * i, 120, 0));
    for (int i = 1; i < 4; i++) exp_q.push_back(ent(64 * i, 144, 'h0F0));
    for (int i = 1; i < 4; i++) exp_q.push_back(ent(64 * i, 144, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(64 * i, 168, 'h00F));
    checks++; if (kq.size() - b !== 14) begin errors++; $display("FAIL oor_kicks: got %0d required 14", kq.size() - b); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (b + i < kq.size()) ? kq[b + i] : 'x;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL oor_box[%0d]: got %h required %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    bit ok; bit seen; int b; int f; logic [27:0] exp_q[$]; logic [27:0] got;
    b = kq.size();
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    for (int n = 0; n < 200 && kq.size() < b + 3; n++) @(negedge clk);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (pnt.kick) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL midreset_no_kick: no kick within 20 cycles of the clear"); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (pnt.kick !== 1'b0 || seq_busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: kick=%b seq_busy=%b frame_done=%b, required 0", pnt.kick, seq_busy, frame_done);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    b = kq.size(); f = fd_cnt;
    wait_done(f + 2, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout: fd=%0d required %0d", fd_cnt, f + 2); end
    checks++; if (kq.size() - b !== 204) begin errors++; $display("FAIL midreset_kicks: got %0d required 204", kq.size() - b); end
    exp_q = '{ent(0, 0, 0), ent(64, 0, 0)};
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(64 * i, 168, 'h00F));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < 2) ? ((b + i < kq.size()) ? kq[b + i] : 'x) : ((b + 198 + i < kq.size()) ? kq[b + 198 + i] : 'x);
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL midreset_box[%0d]: got %h required %h", i, got, exp_q[i]); end
    end
    got = (b + 199 < kq.size()) ? kq[b + 199] : 'x;
    checks++; if (got !== ent(576, 456, 0)) begin errors++; $display("FAIL midreset_last_clear: got %h required %h", got, ent(576, 456, 0)); end
  endtask

  task automatic test_protocol();
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL protocol_kick_while_busy: got %0d required 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_coalesce();
    test_clear_abort();
    test_out_of_range();
    test_reset_mid_clear();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cell_redraw_seq.md
# cell_redraw_seq

Parametrised display sequencer between the game core and the box painter. It clears the whole `COLS`×`ROWS` playfield after reset or on request. It redraws a multi-cell active piece with an erase-old / draw-new sequence, skipping erases of cells the new piece still occupies. Redraw requests that arrive while busy are coalesced, and all painter starts are issued one box at a time over the start/busy/done handshake.

## Interface
- `COLS`, 10, playfield columns
- `ROWS`, 20, playfield rows
- `CXW`, 4, column index width
- `CYW`, 5, row index width
- `CELL_W`, 64, cell width in pixels
- `CELL_H`, 24, cell height in pixels
- `NCELLS`, 4, cells per active piece
- `XW`, 10, pixel x width
- `YW`, 9, pixel y width
- `CW`, 9, colour width (3:3:3)
- `BG_COLOR`, 0, erase/clear colour

Ports:
- `CLOCK_50` in 1 — sole clock, all logic on rising edge
- `resetn` in 1 — reset, asynchronous, active-low
- `clear_req` in 1 — 1-cycle pulse: repaint whole field with `BG_COLOR`
- `redraw_req` in 1 — 1-cycle pulse: active piece moved or changed
- `cur_x` in NCELLS*CXW — cell k column at bits [k*CXW +: CXW]
- `cur_y` in NCELLS*CYW — cell k row, same packing
- `cur_color` in CW — piece colour
- `kick` out 1 — painter start, 1-cycle pulse
- `x0` out XW — box pixel x
- `y0` out YW — box pixel y
- `paint_color` out CW — box colour
- `busy` in 1 — painter busy
- `done` in 1 — painter done, 1-cycle pulse
- `seq_busy` out 1 — sequencer not idle
- `frame_done` out 1 — 1-cycle pulse when a clear or redraw sequence completes

## Operation
- States: `IDLE`, `CLR_ISSUE`, `CLR_WAIT`, `ERS_ISSUE`, `ERS_WAIT`, `DRW_ISSUE`, `DRW_WAIT`.
- Reset state:
  - all outputs 0, state `CLR_ISSUE`, cursor (0,0)
  - `clr_pend`=0, `draw_pend`=1 (forced first draw), `prev_valid`=0
- Box addressing:
  - `x0 = cx*CELL_W`, `y0 = cy*CELL_H`, products truncated to XW/YW.
  - Coordinates and colour are registered in the same cycle `kick` is asserted.
- `*_ISSUE` states:
  - Wait for `busy`=0, then assert `kick` for one cycle and go to the matching `*_WAIT` state.
- `*_WAIT` states:
  - Wait for `done`=1, then advance.
  - `kick` is never reasserted before `done`.
- Clear sequence:
  - Row-major scan, x fastest, of all COLS*ROWS boxes in `BG_COLOR`.
  - After the last box: `prev_valid`←0, `frame_done` pulses.
  - Then go to `ERS_ISSUE` if `draw_pend`, else `IDLE`.
- Redraw sequence:
  - On entry, snapshot `cur_x`/`cur_y`/`cur_color` into `new_*` and clear `draw_pend`.
  - Erase phase scans prev cells k=0..NCELLS-1. A cell is skipped (no kick, 1 cycle per skipped cell) if:
    - `prev_valid`=0, or
    - the cell equals any `new` cell, or
    - the cell is out of range (x≥COLS or y≥ROWS).
  - Draw phase scans `new` cells k=0..NCELLS-1 in `new_color`, skipping out-of-range cells.
  - On completion: `prev`←`new`, `prev_valid`←1, `frame_done` pulses.
- Requests:
  - `redraw_req` in `IDLE` starts the redraw next cycle.
  - `redraw_req` while `seq_busy` sets `draw_pend`. Any number of requests coalesce into one follow-up.
  - `clear_req` at any time sets `clr_pend`.
- Priority at every box boundary (after `done`, or in `IDLE`):
  - `clr_pend` first: abort the current sequence and restart the clear from (0,0).
  - Then `draw_pend`.
  - A box in flight is never aborted.
- An aborted redraw leaves `prev` unchanged. The subsequent clear invalidates it.
- `seq_busy` = state≠`IDLE`.

## Timing
- `redraw_req` at cycle t in `IDLE` with painter idle: first `kick` at t+2.
- Two consecutive kicks are separated by the painter's done plus 1 cycle.
- Full clear issues exactly COLS*ROWS kicks (200 at defaults).
- Redraw kick count = (non-skipped erases) + (in-range draws).
- `frame_done` is asserted the cycle after the final `done` of a sequence.
- A request arriving in the same cycle as `frame_done` is pended and served immediately after.
- `resetn` low mid-sequence:
  - Outputs go to 0 asynchronously.
  - On release the sequencer restarts the clear.
  - The painter is expected to be reset by the same `resetn`.

## Test plan
- Reset release, painter modelled with 5-cycle busy: 200 BG kicks with x0 = 0..576 step 64 and y0 = 0..456 step 24, then 4 piece-colour kicks at the `cur` cells, then one `frame_done`.
- I-piece at (3..6,0), shifted to (4..7,0) with `redraw_req`: 1 erase at (192,0), then 4 draws at x=256,320,384,448, y0=0.
- Three `redraw_req` pulses during a busy redraw: exactly one follow-up sequence, using the `cur` values sampled at its start.
- `clear_req` during the erase phase: the in-flight box completes, then 200 clear kicks, then the pending redraw draws with no erases.
- A piece cell at x=12 (out of range): no kick for that cell in either phase; the other 3 cells are drawn.
- `resetn` pulsed low mid-clear: `kick`, `seq_busy` and `frame_done` drop to 0 immediately; after release the clear restarts at (0,0).
